// File: rtl/alu_activacion_pkg.sv
// Shared types and fixed-point helpers for the piecewise-linear activation ALU.
package alu_activacion_pkg;

    typedef enum logic [1:0] {
        ModePwl   = 2'd0,
        ModeIdent = 2'd1,
        ModeRelu  = 2'd2,
        ModeHsat  = 2'd3
    } mode_e;

    // Wide intermediate: val holds the clamped result, ovf marks a clamp.
    typedef struct packed {
        logic [63:0] val;
        logic        ovf;
    } sat_t;

    function automatic logic signed [63:0] one_val(input int unsigned precision);
        return 64'sd1 <<< precision;
    endfunction

    function automatic logic signed [63:0] sat_max(input int unsigned width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    // Round half-up, arithmetic shift right by 'shift', clamp to a signed 'width' range.
    function automatic sat_t sat_round(input logic signed [63:0] x,
                                       input int unsigned       shift,
                                       input int unsigned       width);
        sat_t                r;
        logic signed [63:0]  t;
        t = x;
        if (shift != 0) begin
            t = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        r.val = t;
        r.ovf = 1'b0;
        if (t > sat_max(width)) begin
            r.val = sat_max(width);
            r.ovf = 1'b1;
        end else if (t < sat_min(width)) begin
            r.val = sat_min(width);
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_activacion_pwl_if.sv
// Sample stream, coefficient-load and error signals of the activation ALU.
interface alu_activacion_pwl_if #(
    parameter int unsigned Width   = 24,
    parameter int unsigned SegBits = 5
);
    logic                    cfg_we;
    logic [SegBits-1:0]      cfg_addr;
    logic signed [Width-1:0] cfg_m;
    logic signed [Width-1:0] cfg_b;
    logic [1:0]              mode;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [Width-1:0] In;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [Width-1:0] Out;
    logic                    err_clr;
    logic                    Error;

    modport master (
        output cfg_we, cfg_addr, cfg_m, cfg_b, mode, in_valid, In, out_ready, err_clr,
        input  in_ready, out_valid, Out, Error
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_m, cfg_b, mode, in_valid, In, out_ready, err_clr,
        output in_ready, out_valid, Out, Error
    );
endinterface

// File: rtl/pwl_mac_sat.sv
// S2/S3 datapath: rounded saturating multiply, then saturating add of the offset.
module pwl_mac_sat
    import alu_activacion_pkg::*;
#(
    parameter int unsigned Width     = 24,
    parameter int unsigned Precision = 19
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    adv_i,
    input  logic signed [Width-1:0] x_i,
    input  logic signed [Width-1:0] m_i,
    input  logic signed [Width-1:0] b_i,
    output logic signed [Width-1:0] sum_o,
    output logic                    mul_ovf_o,
    output logic                    sum_ovf_o
);
    logic signed [2*Width-1:0] prod_full;
    logic signed [Width:0]     sum_full;
    sat_t                      mul_sat;
    sat_t                      sum_sat;
    logic signed [Width-1:0]   prod_q;
    logic signed [Width-1:0]   b_q;
    logic signed [Width-1:0]   sum_q;
    logic                      mul_ovf_q;
    logic                      unused_hi;

    assign prod_full = (2*Width)'(m_i) * (2*Width)'(x_i);
    assign sum_full  = (Width+1)'(prod_q) + (Width+1)'(b_q);

    // Clamp both arithmetic results to the word range.
    always_comb begin
        mul_sat = sat_round(64'(prod_full), Precision, Width);
        sum_sat = sat_round(64'(sum_full), 0, Width);
    end

    // S2 and S3 registers, frozen together while the pipe is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q    <= '0;
            b_q       <= '0;
            mul_ovf_q <= 1'b0;
            sum_q     <= '0;
        end else if (adv_i) begin
            prod_q    <= mul_sat.val[Width-1:0];
            b_q       <= b_i;
            mul_ovf_q <= mul_sat.ovf;
            sum_q     <= sum_sat.val[Width-1:0];
        end
    end

    // Overflow flags describe the sample about to enter S3.
    assign sum_o     = sum_q;
    assign mul_ovf_o = mul_ovf_q;
    assign sum_ovf_o = sum_sat.ovf;
    assign unused_hi = ^{mul_sat.val[63:Width], sum_sat.val[63:Width]};
endmodule

// File: rtl/alu_activacion_pwl.sv
// Three-stage piecewise-linear activation ALU with loadable slope/offset table.
module alu_activacion_pwl
    import alu_activacion_pkg::*;
#(
    parameter int unsigned Width     = 24,
    parameter int unsigned Magnitud  = 4,
    parameter int unsigned Precision = 19,
    parameter int unsigned Signo     = 1,
    parameter int unsigned SegBits   = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_activacion_pwl_if.slave bus
);
    localparam int unsigned NSeg = 2 ** SegBits;
    localparam logic signed [Width-1:0] One = Width'(one_val(Precision));

    if (Width != Signo + Magnitud + Precision) begin : g_width_chk
        $error("Width must equal Signo + Magnitud + Precision");
    end

    logic signed [Width-1:0] m_tbl_q [NSeg];
    logic signed [Width-1:0] b_tbl_q [NSeg];
    logic                    advance;
    logic [SegBits-1:0]      seg;
    logic                    v1_q, v2_q, v3_q;
    logic signed [Width-1:0] x1_q, x2_q, x3_q;
    logic [SegBits-1:0]      seg1_q, seg2_q, seg3_q;
    mode_e                   mode1_q, mode2_q, mode3_q;
    logic signed [Width-1:0] m1_q, b1_q;
    logic signed [Width-1:0] sum;
    logic                    mul_ovf, sum_ovf;
    logic                    error_q;
    logic signed [Width-1:0] out_val;

    assign advance = !v3_q || bus.out_ready;
    // Flipping the sign bit maps the signed range onto ascending segment indices.
    assign seg = {~bus.In[Width-1], bus.In[Width-2 -: SegBits-1]};

    // Coefficient table; a write lands on the edge, so same-edge reads see old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSeg; i++) begin
                m_tbl_q[i] <= '0;
                b_tbl_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            m_tbl_q[bus.cfg_addr] <= bus.cfg_m;
            b_tbl_q[bus.cfg_addr] <= bus.cfg_b;
        end
    end

    // S1 capture plus sideband carried alongside the S2/S3 datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            seg1_q  <= '0;
            seg2_q  <= '0;
            seg3_q  <= '0;
            mode1_q <= ModePwl;
            mode2_q <= ModePwl;
            mode3_q <= ModePwl;
            m1_q    <= '0;
            b1_q    <= '0;
        end else if (advance) begin
            v1_q    <= bus.in_valid;
            x1_q    <= bus.In;
            seg1_q  <= seg;
            mode1_q <= mode_e'(bus.mode);
            m1_q    <= m_tbl_q[seg];
            b1_q    <= b_tbl_q[seg];
            v2_q    <= v1_q;
            x2_q    <= x1_q;
            seg2_q  <= seg1_q;
            mode2_q <= mode1_q;
            v3_q    <= v2_q;
            x3_q    <= x2_q;
            seg3_q  <= seg2_q;
            mode3_q <= mode2_q;
        end
    end

    pwl_mac_sat #(
        .Width     (Width),
        .Precision (Precision)
    ) u_mac (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .adv_i     (advance),
        .x_i       (x1_q),
        .m_i       (m1_q),
        .b_i       (b1_q),
        .sum_o     (sum),
        .mul_ovf_o (mul_ovf),
        .sum_ovf_o (sum_ovf)
    );

    // Sticky overflow: a set on the same edge as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else if (advance && v2_q && mode2_q == ModePwl && (mul_ovf || sum_ovf)) begin
            error_q <= 1'b1;
        end else if (bus.err_clr) begin
            error_q <= 1'b0;
        end
    end

    // Output selection by the mode captured with the sample.
    always_comb begin
        out_val = sum;
        unique case (mode3_q)
            ModePwl: begin
                if (seg3_q == '0) begin
                    out_val = '0;
                end else if (&seg3_q) begin
                    out_val = One;
                end
            end
            ModeIdent: out_val = x3_q;
            ModeRelu:  out_val = x3_q[Width-1] ? '0 : x3_q;
            ModeHsat:  out_val = x3_q[Width-1] ? '0 : ((x3_q > One) ? One : x3_q);
        endcase
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v3_q;
    assign bus.Out       = out_val;
    assign bus.Error     = error_q;
endmodule

// File: tb/tb_alu_activacion_pwl.sv
// Scoreboard bench for the piecewise-linear activation ALU.
module tb_alu_activacion_pwl;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [23:0] sb[$];

    alu_activacion_pwl_if #(.Width(24), .SegBits(5)) bus ();

    alu_activacion_pwl #(
        .Width     (24),
        .Magnitud  (4),
        .Precision (19),
        .Signo     (1),
        .SegBits   (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input logic [4:0] a, input logic [23:0] m, input logic [23:0] b);
        bus.cfg_we = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_m = m;
        bus.cfg_b = b;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
    endtask

    // Offers one sample until accepted; expected result goes to the scoreboard on acceptance.
    task automatic push_sample(input logic [23:0] x, input logic [1:0] m, input logic [23:0] e);
        int n;
        bus.In = x;
        bus.mode = m;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            errors++;
            $display("FAIL push_timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid);
        end
        checks++;
        if (bus.Out !== 24'h0) begin
            errors++;
            $display("FAIL reset_out: got %h want 000000", bus.Out);
        end
        checks++;
        if (bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL reset_error: got %0b want 0", bus.Error);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pwl();
        int n;
        logic [23:0] e;
        cfg_write(5'd17, 24'h040000, 24'h020000);
        push_sample(24'h0C0000, 2'd0, 24'h080000);
        wait_out(n);
        checks++;
        if (n !== 3 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pwl_latency: got %0d cycles valid=%0b want 3 valid=1", n, bus.out_valid);
        end
        e = sb.pop_front();
        checks++;
        if (bus.Out !== e) begin
            errors++;
            $display("FAIL pwl_out: got %h want %h", bus.Out, e);
        end
        checks++;
        if (bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL pwl_error: got %0b want 0", bus.Error);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_edge_segs();
        logic [23:0] ins [2];
        int n;
        logic [23:0] e;
        ins = '{24'h800000, 24'h7C0000};
        cfg_write(5'd0, 24'h080000, 24'h010000);
        cfg_write(5'd31, 24'h080000, 24'h010000);
        push_sample(ins[0], 2'd0, 24'h000000);
        push_sample(ins[1], 2'd0, 24'h080000);
        for (int i = 0; i < 2; i++) begin
            wait_out(n);
            e = sb.pop_front();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.Out !== e) begin
                errors++;
                $display("FAIL edge_seg%0d: got %h valid=%0b want %h", i, bus.Out, bus.out_valid, e);
            end
        end
        checks++;
        if (bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL edge_error: got %0b want 0", bus.Error);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_error();
        int n;
        logic [23:0] e;
        cfg_write(5'd20, 24'h200000, 24'h000000);
        push_sample(24'h200000, 2'd0, 24'h7FFFFF);
        wait_out(n);
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Out !== e || bus.Error !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat: got %h err=%0b want %h err=1", bus.Out, bus.Error, e);
        end
        @(posedge clk);
        #1;
        push_sample(24'h0C0000, 2'd0, 24'h080000);
        wait_out(n);
        e = sb.pop_front();
        checks++;
        if (bus.Out !== e || bus.Error !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %h err=%0b want %h err=1", bus.Out, bus.Error, e);
        end
        @(posedge clk);
        #1;
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        checks++;
        if (bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %0b want 0", bus.Error);
        end
        // Clear held high while an overflowing sample reaches S3.
        bus.err_clr = 1'b1;
        push_sample(24'h200000, 2'd0, 24'h7FFFFF);
        wait_out(n);
        e = sb.pop_front();
        checks++;
        if (bus.Out !== e || bus.Error !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins: got %h err=%0b want %h err=1", bus.Out, bus.Error, e);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL err_clr_after: got %0b want 0", bus.Error);
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] ins [7];
        logic [1:0]  ms [7];
        logic [23:0] ex [7];
        ins = '{24'hF00000, 24'h180000, 24'h180000, 24'hABCDEF, 24'hF00000, 24'h040000, 24'h0C0000};
        ms  = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd0};
        ex  = '{24'h000000, 24'h180000, 24'h080000, 24'hABCDEF, 24'h000000, 24'h040000, 24'h080000};
        fork
            begin
                for (int i = 0; i < 7; i++) push_sample(ins[i], ms[i], ex[i]);
            end
            begin
                int n;
                logic [23:0] e;
                for (int j = 0; j < 7; j++) begin
                    wait_out(n);
                    if (!bus.out_valid || sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b2b_timeout%0d: valid=%0b queued=%0d", j, bus.out_valid, sb.size());
                    end else begin
                        e = sb.pop_front();
                        checks++;
                        if (bus.Out !== e) begin
                            errors++;
                            $display("FAIL b2b_out%0d: got %h want %h", j, bus.Out, e);
                        end
                        if (j > 0) begin
                            checks++;
                            if (n !== 1) begin
                                errors++;
                                $display("FAIL b2b_rate%0d: got gap %0d want 1", j, n);
                            end
                        end
                    end
                end
            end
        join
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [23:0] vals [6];
        logic [23:0] held_val;
        logic [23:0] e;
        bit          held;
        bit          acc_now;
        int          k;
        vals = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 24'h000000};
        held = 1'b0;
        held_val = '0;
        k = 0;
        bus.out_ready = 1'b0;
        bus.mode = 2'd1;
        bus.In = vals[0];
        bus.in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                if (!held) begin
                    held = 1'b1;
                    held_val = bus.Out;
                end else begin
                    checks++;
                    if (bus.Out !== held_val) begin
                        errors++;
                        $display("FAIL stall_hold%0d: got %h want %h", c, bus.Out, held_val);
                    end
                end
            end
            acc_now = bus.in_ready && bus.in_valid;
            @(posedge clk);
            #1;
            if (acc_now) begin
                sb.push_back(vals[k]);
                k++;
                if (k >= 5) bus.in_valid = 1'b0;
                else bus.In = vals[k];
            end
        end
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL stall_accepted: got %0d want 3", k);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_in_ready: got %0b want 0", bus.in_ready);
        end
        checks++;
        if (held_val !== vals[0]) begin
            errors++;
            $display("FAIL stall_first: got %h want %h", held_val, vals[0]);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = (sb.size() != 0) ? sb.pop_front() : 24'hXXXXXX;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.Out !== e) begin
                errors++;
                $display("FAIL drain%0d: got %h valid=%0b want %h", i, bus.Out, bus.out_valid, e);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: got valid=%0b want 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        int n;
        logic [23:0] e;
        bus.mode = 2'd0;
        push_sample(24'h200000, 2'd0, 24'h7FFFFF);
        push_sample(24'h0C0000, 2'd0, 24'h080000);
        push_sample(24'h0C0000, 2'd0, 24'h080000);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Error !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got valid=%0b err=%0b want 1 1", bus.out_valid, bus.Error);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.Out !== 24'h0 || bus.Error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b out=%h err=%0b want 0 000000 0",
                     bus.out_valid, bus.Out, bus.Error);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL ghost_out%0d: got valid=%0b want 0", i, bus.out_valid);
            end
        end
        @(posedge clk);
        #1;
        push_sample(24'h0C0000, 2'd0, 24'h000000);
        wait_out(n);
        e = sb.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Out !== e) begin
            errors++;
            $display("FAIL table_cleared: got %h valid=%0b want %h", bus.Out, bus.out_valid, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_m = '0;
        bus.cfg_b = '0;
        bus.mode = 2'd0;
        bus.in_valid = 1'b0;
        bus.In = '0;
        bus.out_ready = 1'b1;
        bus.err_clr = 1'b0;
        test_reset();
        test_pwl();
        test_edge_segs();
        test_error();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
